// File: rtl/pe_mac_responder.sv
// PE-side command responder: accepts one MAC/clear command, runs an iterative
// shift-add multiply, accumulates, and signals completion with ready+done.
package nmcu_pkg;
  localparam int unsigned DATA_WIDTH = 32;
endpackage

package instr_pkg;
  typedef logic [7:0] opcode_t;
  localparam opcode_t INSTR_NOP = 8'h00;
  localparam opcode_t INSTR_MAC = 8'h01;
  typedef struct packed {
    opcode_t opcode;
  } instruction_t;
endpackage

module pe_mac_responder #(
  parameter int unsigned DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pe_cmd_valid_i,
  input  instr_pkg::instruction_t pe_cmd_i,
  input  logic [DATA_WIDTH-1:0]   pe_operand_a_i,
  input  logic [DATA_WIDTH-1:0]   pe_operand_b_i,
  output logic                    pe_cmd_ready_o,
  output logic                    pe_done_o,
  output logic [DATA_WIDTH-1:0]   pe_result_o,
  output logic                    pe_busy_o
);

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [DATA_WIDTH-1:0] prod_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  busy_q;

  // Control FSM and datapath; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pe_cmd_valid_i) begin
            mcand_q  <= pe_operand_a_i;
            mplier_q <= pe_operand_b_i;
            prod_q   <= '0;
            cnt_q    <= CNT_WIDTH'(DATA_WIDTH);
            busy_q   <= 1'b1;
            if (pe_cmd_i.opcode == instr_pkg::INSTR_MAC) begin
              state_q <= MUL;
              ready_q <= 1'b0;
            end else begin
              // Any non-MAC opcode is a clear: zero the accumulator and result.
              state_q  <= DONE;
              acc_q    <= '0;
              result_q <= '0;
              ready_q  <= 1'b1;
              done_q   <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_q <= ACC;
          end
        end
        ACC: begin
          acc_q    <= acc_q + prod_q;
          result_q <= acc_q + prod_q;
          state_q  <= DONE;
          ready_q  <= 1'b1;
          done_q   <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pe_cmd_ready_o = ready_q;
  assign pe_done_o      = done_q;
  assign pe_result_o    = result_q;
  assign pe_busy_o      = busy_q;

endmodule

// File: tb/tb_pe_mac_responder.sv
// Bench for pe_mac_responder: cycle-level behavioural model plus directed and
// randomized command sequences with literal result/latency expectations.
module tb_pe_mac_responder;

  localparam int unsigned DW      = 32;
  localparam int unsigned MAC_LAT = DW + 2;

  logic                    clk;
  logic                    rst;
  logic                    valid;
  instr_pkg::instruction_t cmd;
  logic [DW-1:0]           op_a;
  logic [DW-1:0]           op_b;
  logic                    ready;
  logic                    done;
  logic [DW-1:0]           result;
  logic                    busy;

  pe_mac_responder dut (
    .clk            (clk),
    .rst            (rst),
    .pe_cmd_valid_i (valid),
    .pe_cmd_i       (cmd),
    .pe_operand_a_i (op_a),
    .pe_operand_b_i (op_b),
    .pe_cmd_ready_o (ready),
    .pe_done_o      (done),
    .pe_result_o    (result),
    .pe_busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Behavioural model: a command occupies the unit for a fixed latency, and its
  // result is acc + a*b (mod 2^DW) for MAC or zero for anything else.
  logic [DW-1:0] m_acc  = '0;
  logic [DW-1:0] m_res  = '0;
  logic [DW-1:0] m_pend = '0;
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  int            m_cnt  = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_acc = '0; m_cnt = 0;
    end else if (!m_busy) begin
      if (valid) begin
        m_busy = 1'b1;
        if (cmd.opcode == instr_pkg::INSTR_MAC) begin
          m_pend = m_acc + op_a * op_b;
          m_cnt  = MAC_LAT - 1;
          m_done = 1'b0;
        end else begin
          m_acc = '0; m_res = '0; m_cnt = 0; m_done = 1'b1;
        end
      end
    end else if (m_done) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1'b1; m_res = m_pend; m_acc = m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", DW'(ready), DW'(!m_busy || m_done));
      check("done",  DW'(done),  DW'(m_done));
      check("busy",  DW'(busy),  DW'(m_busy));
      check("result", result, m_res);
    end
  end

  int t_acc;

  // Present a command and return just after the accept edge with valid still high.
  task automatic start(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk); #1;
    cmd.opcode = op; op_a = a; op_b = b; valid = 1'b1;
    @(posedge clk); #1;
    t_acc = cyc - 1;
  endtask

  // Wait (bounded) for the done pulse; check its cycle and the result literal.
  task automatic finish(input string name, input int lat, input logic [DW-1:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout cyc=%0d got=no_done exp=done", name, cyc);
    end else begin
      check({name, "_lat"}, DW'(cyc - t_acc), DW'(lat));
      check({name, "_res"}, result, exp);
      check({name, "_rdy"}, DW'(ready), DW'(1));
    end
  endtask

  task automatic run(input string name, input logic [7:0] op, input logic [DW-1:0] a,
                     input logic [DW-1:0] b, input logic [DW-1:0] exp);
    start(op, a, b);
    valid = 1'b0;
    finish(name, (op == instr_pkg::INSTR_MAC) ? MAC_LAT : 1, exp);
  endtask

  initial begin
    bit saw;
    logic [7:0] rop;
    rst = 1'b1; valid = 1'b0; cmd.opcode = instr_pkg::INSTR_NOP; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", DW'(ready), DW'(1));
    check("rst_done", DW'(done), DW'(0));
    check("rst_result", result, '0);
    check("rst_busy", DW'(busy), DW'(0));

    run("mac_3x4", instr_pkg::INSTR_MAC, 3, 4, 12);
    @(negedge clk);
    check("idle_busy", DW'(busy), DW'(0));
    check("idle_ready", DW'(ready), DW'(1));
    run("mac_5x6", instr_pkg::INSTR_MAC, 5, 6, 42);
    run("nop", instr_pkg::INSTR_NOP, 77, 88, 0);
    run("mac_2x2", instr_pkg::INSTR_MAC, 2, 2, 4);

    run("clr", 8'h5A, 0, 0, 0);
    run("ovf", instr_pkg::INSTR_MAC, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    run("wrap", instr_pkg::INSTR_MAC, 1, 3, 32'h0000_0001);
    run("clr2", instr_pkg::INSTR_NOP, 0, 0, 0);

    // Inputs change and valid drops mid-operation.
    start(instr_pkg::INSTR_MAC, 7, 8);
    repeat (4) @(posedge clk);
    #1 op_a = 9; op_b = 9; valid = 1'b0;
    finish("hold", MAC_LAT, 56);

    // Reset during MUL cycle 10 drops the command without a done.
    start(instr_pkg::INSTR_MAC, 11, 13);
    valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", DW'(busy), DW'(0));
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw = 1'b1;
    end
    check("midrst_nodone", DW'(saw), DW'(0));
    check("midrst_result", result, '0);
    run("post_rst", instr_pkg::INSTR_MAC, 2, 3, 6);

    // Valid held through DONE, dropped one cycle late.
    start(instr_pkg::INSTR_MAC, 1, 1);
    finish("late_drop", MAC_LAT, 7);
    @(posedge clk); #1 valid = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    check("late_drop_single", DW'(saw), DW'(0));

    for (int n = 0; n < 24; n++) begin
      rop = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 255)) : instr_pkg::INSTR_MAC;
      if (n % 3 == 0) begin
        start(rop, $urandom, $urandom);
      end else begin
        start(rop, DW'($urandom_range(0, 1000)), DW'($urandom_range(0, 1000)));
      end
      valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (done === 1'b1) break;
      end
      check("rand_done", DW'(done), DW'(1));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_mac_responder.md
Name: pe_mac_responder

Overview:
- PE-side responder for the control unit's PE command interface (`pe_cmd_valid`/`pe_cmd_ready`/`pe_done`/`pe_result`).
- Accepts one command with two operands and performs an iterative unsigned shift-add multiply-accumulate.
- Returns the result with `pe_cmd_ready_o` and `pe_done_o` asserted together, which is the completion condition the control unit checks.
- Sits between the control unit and the PE array datapath; one command in flight at a time.

Parameters:
- DATA_WIDTH, nmcu_pkg::DATA_WIDTH (32): operand, accumulator and result width.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1: width of the multiply iteration counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- pe_cmd_valid_i  input  1  command and operands valid; held by the initiator until completion
- pe_cmd_i  input  instr_pkg::instruction_t  command metadata; only opcode is used
- pe_operand_a_i  input  DATA_WIDTH  multiplicand
- pe_operand_b_i  input  DATA_WIDTH  multiplier
- pe_cmd_ready_o  output  1  high in IDLE (accept) and in DONE (completion)
- pe_done_o  output  1  one-cycle completion pulse, high only in DONE
- pe_result_o  output  DATA_WIDTH  result; valid while pe_done_o=1 and held until the next accept
- pe_busy_o  output  1  high in MUL, ACC and DONE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; acc, product, result, counter and latched operands cleared to 0.
  - Outputs after reset: pe_cmd_ready_o=1, pe_done_o=0, pe_result_o=0, pe_busy_o=0.
  - Reset overrides all other activity, including mid-MUL; any in-flight command is dropped with no done.
- States: IDLE, MUL, ACC, DONE.
- IDLE:
  - pe_cmd_ready_o=1.
  - Accept when pe_cmd_valid_i=1 at the edge: latch opcode, operand A into multiplicand register, operand B into multiplier register; clear product; counter=DATA_WIDTH.
  - opcode==INSTR_MAC -> MUL. Any other opcode -> DONE with result=0 and acc cleared to 0 (clear command).
- MUL:
  - Each cycle: if multiplier[0], product += multiplicand; then multiplicand <<= 1, multiplier >>= 1, counter -= 1.
  - All arithmetic is modulo 2^DATA_WIDTH; carries out of the top bit are discarded.
  - Exactly DATA_WIDTH cycles (no early termination), then -> ACC when the counter reaches 0.
- ACC:
  - result = acc + product (mod 2^DATA_WIDTH); acc = same value. -> DONE.
- DONE:
  - pe_done_o=1 and pe_cmd_ready_o=1 for exactly one cycle, then -> IDLE unconditionally.
  - A valid seen in DONE is never treated as a new command; the initiator drops valid the cycle after completion.
- Latency, with the accept edge at the end of cycle T:
  - MAC: done high in cycle T+DATA_WIDTH+2.
  - Non-MAC: done high in cycle T+1.
- Input hold rules:
  - Operands and opcode are sampled only at accept; later input changes, or valid dropping mid-operation, have no effect.
  - The operation completes and done still pulses.
- Back-to-back: a new accept is possible in the IDLE cycle directly following DONE.
- Accumulator persistence: acc persists across MAC commands; it is cleared only by reset or a non-MAC command.
- Result register: pe_result_o changes only on entry to DONE and on reset.

Test Plan:
- Reset, then MAC a=3, b=4 accepted at T -> done and ready high only in cycle T+34, result=12, busy low in T+35, ready stays high in IDLE.
- Follow-up MAC a=5, b=6 -> result=42 (12+30); then NOP -> done at T'+1, result=0; then MAC a=2, b=2 -> result=4.
- Overflow: MAC a=0xFFFF_FFFF, b=2 from cleared acc -> result=0xFFFF_FFFE; then MAC a=1, b=3 -> result=0x0000_0001 (wrap).
- Inputs changed to a=9, b=9 and valid dropped 5 cycles after accepting a=7, b=8 -> done still at T+34, result=56.
- rst asserted at MUL cycle 10 for one cycle -> next cycle state IDLE, done never pulses, result=0, acc=0; a new MAC a=2, b=3 -> 6.
- Valid held high through DONE, modelling the initiator's one-cycle-late drop -> exactly one done pulse, no second accept, busy=0 after DONE.
